// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches one word at a time and computes the next PC for decode.
// Optional misaligned-target trap enabled by defining INSTRUCTION_FETCH_MISALIGN_TRAP_EN.
module instruction_fetch #(
  parameter int              WORD         = 32,
  parameter logic [WORD-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WORD-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter logic [WORD-1:0] NOP_WORD     = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      pc_select,
  input  logic [WORD-1:0] immediate,
  input  logic [WORD-1:0] rs1_data,
  input  logic            branch_taken,
  output logic [WORD-1:0] imem_addr,
  output logic            imem_req,
  input  logic [WORD-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [WORD-1:0] instruction,
  output logic            instr_valid,
  output logic [WORD-1:0] pc,
  output logic [WORD-1:0] pc_plus4,
  output logic            misaligned
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam logic [WORD-1:0] FOUR = WORD'(32'd4);

  state_t          state_r;
  state_t          state_next_s;
  logic [WORD-1:0] pc_r;
  logic [WORD-1:0] instr_r;
  logic            instr_valid_r;
  logic [WORD-1:0] raw_target_s;
  logic [WORD-1:0] next_pc_s;
  logic            hold_s;
  logic            load_instr_s;
  logic            advance_s;

  // Raw next-PC target selected by the decoder code
  always_comb begin
    raw_target_s = pc_r + FOUR;
    case (pc_select)
      3'd0: raw_target_s = pc_r + FOUR;
      3'd1: begin
        if (branch_taken) begin
          raw_target_s = pc_r + immediate;
        end else begin
          raw_target_s = pc_r + FOUR;
        end
      end
      3'd2:    raw_target_s = pc_r + immediate;
      3'd3:    raw_target_s = (rs1_data + immediate) & ~(WORD'(32'd1));
      3'd4:    raw_target_s = pc_r + FOUR;
      default: raw_target_s = pc_r + FOUR;
    endcase
  end

  assign hold_s = (pc_select >= 3'd5);

`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
  logic misalign_s;
  logic misaligned_r;

  assign misalign_s = (raw_target_s[1:0] != 2'b00);
  assign next_pc_s  = misalign_s ? TRAP_VECTOR : raw_target_s;
  assign misaligned = misaligned_r;

  // Sticky misaligned flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_r <= 1'b0;
    end else if (advance_s && misalign_s) begin
      misaligned_r <= 1'b1;
    end
  end
`else
  assign next_pc_s  = {raw_target_s[WORD-1:2], raw_target_s[1:0] & 2'b00};
  assign misaligned = 1'b0;
`endif

  // Next-state and datapath enables
  always_comb begin
    state_next_s = state_r;
    load_instr_s = 1'b0;
    advance_s    = 1'b0;
    case (state_r)
      BOOT: state_next_s = FETCH;
      FETCH: begin
        if (imem_ready) begin
          load_instr_s = 1'b1;
          state_next_s = EXEC;
        end else begin
          state_next_s = FETCH;
        end
      end
      EXEC: begin
        if (hold_s) begin
          state_next_s = EXEC;
        end else begin
          advance_s    = 1'b1;
          state_next_s = FETCH;
        end
      end
      default: state_next_s = BOOT;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // PC and held instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= RESET_VECTOR;
      instr_r       <= NOP_WORD;
      instr_valid_r <= 1'b0;
    end else if (load_instr_s) begin
      instr_r       <= imem_rdata;
      instr_valid_r <= 1'b1;
    end else if (advance_s) begin
      pc_r          <= next_pc_s;
      instr_valid_r <= 1'b0;
    end
  end

  assign imem_req    = (state_r == FETCH);
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_r + FOUR;
  assign instr_valid = instr_valid_r;
  assign instruction = instr_valid_r ? instr_r : NOP_WORD;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; expectations follow INSTRUCTION_FETCH_MISALIGN_TRAP_EN.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [2:0]  pc_select;
  logic [31:0] immediate;
  logic [31:0] rs1_data;
  logic        branch_taken;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;

  int vectors;
  int miscompares;

`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] EXP_MIS_PC  = 32'h0000_0100;
  localparam logic        EXP_MIS_FLG = 1'b1;
`else
  localparam logic [31:0] EXP_MIS_PC  = 32'h0000_0000;
  localparam logic        EXP_MIS_FLG = 1'b0;
`endif

  instruction_fetch dut (
    .clk(clk), .rst(rst), .pc_select(pc_select), .immediate(immediate),
    .rs1_data(rs1_data), .branch_taken(branch_taken), .imem_addr(imem_addr),
    .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .pc_plus4(pc_plus4), .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_select = 3'd0; immediate = 32'd0; rs1_data = 32'd0;
    branch_taken = 1'b0; imem_rdata = 32'd0; imem_ready = 1'b0;
    tick(); tick();
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", imem_req); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    vectors++; if (instruction !== 32'h13) begin miscompares++; $display("FAIL reset_instr: got %h want %h", instruction, 32'h13); end
    vectors++; if (misaligned !== 1'b0) begin miscompares++; $display("FAIL reset_mis: got %b want 0", misaligned); end
  endtask

  task automatic test_fetch_basic();
    imem_ready = 1'b1; imem_rdata = 32'h00A0_0093; pc_select = 3'd0;
    rst = 1'b0;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL boot_req: got %b want 0", imem_req); end
    tick();
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL fetch0_req: got %b want 1", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL fetch0_addr: got %h want %h", imem_addr, 32'h0); end
    tick();
    vectors++; if (instruction !== 32'h00A0_0093) begin miscompares++; $display("FAIL exec0_instr: got %h want %h", instruction, 32'h00A00093); end
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL exec0_valid: got %b want 1", instr_valid); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL exec0_req: got %b want 0", imem_req); end
    vectors++; if (pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL exec0_pc4: got %h want %h", pc_plus4, 32'h4); end
    tick();
    vectors++; if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL fetch4_addr: got %h want %h", imem_addr, 32'h4); end
    vectors++; if (instruction !== 32'h13) begin miscompares++; $display("FAIL fetch4_nop: got %h want %h", instruction, 32'h13); end
    imem_rdata = 32'h0010_0113;
    tick();
    vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL exec4_pc: got %h want %h", pc, 32'h4); end
  endtask

  task automatic test_delayed_ready();
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF; pc_select = 3'd0;
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin miscompares++; $display("FAIL wait_req_addr[%0d]: got %b/%h want 1/%h", i, imem_req, imem_addr, 32'h8); end
      vectors++; if (instr_valid !== 1'b0 || instruction !== 32'h13) begin miscompares++; $display("FAIL wait_nop[%0d]: got %b/%h want 0/%h", i, instr_valid, instruction, 32'h13); end
      tick();
    end
    imem_ready = 1'b1; imem_rdata = 32'h0020_0193;
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL wait_req_last: got %b want 1", imem_req); end
    tick();
    vectors++; if (instruction !== 32'h0020_0193 || imem_req !== 1'b0) begin miscompares++; $display("FAIL delayed_exec: got %h/%b want %h/0", instruction, imem_req, 32'h00200193); end
    pc_select = 3'd2; immediate = 32'h8;
    tick();
    vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL jal_to_10: got %h want %h", imem_addr, 32'h10); end
    tick();
  endtask

  task automatic test_branch();
    pc_select = 3'd1; immediate = 32'hFFFF_FFF8; branch_taken = 1'b1;
    tick();
    vectors++; if (imem_addr !== 32'h8) begin miscompares++; $display("FAIL branch_taken: got %h want %h", imem_addr, 32'h8); end
    tick();
    pc_select = 3'd2; immediate = 32'h8;
    tick(); tick();
    vectors++; if (pc !== 32'h10) begin miscompares++; $display("FAIL back_to_10: got %h want %h", pc, 32'h10); end
    pc_select = 3'd1; immediate = 32'hFFFF_FFF8; branch_taken = 1'b0;
    tick();
    vectors++; if (imem_addr !== 32'h14) begin miscompares++; $display("FAIL branch_not_taken: got %h want %h", imem_addr, 32'h14); end
    tick();
  endtask

  task automatic test_jalr();
    vectors++; if (pc_plus4 !== 32'h18) begin miscompares++; $display("FAIL jalr_link: got %h want %h", pc_plus4, 32'h18); end
    pc_select = 3'd3; rs1_data = 32'h101; immediate = 32'h4;
    tick();
    vectors++; if (pc !== 32'h104) begin miscompares++; $display("FAIL jalr_target: got %h want %h", pc, 32'h104); end
    imem_rdata = 32'h0000_A003;
    tick();
  endtask

  task automatic test_hold();
    pc_select = 3'd5; imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) pc_select = 3'd7;
      tick();
      vectors++; if (pc !== 32'h104 || instruction !== 32'h0000_A003) begin miscompares++; $display("FAIL hold[%0d]: got %h/%h want %h/%h", i, pc, instruction, 32'h104, 32'h0000A003); end
      vectors++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin miscompares++; $display("FAIL hold_ctl[%0d]: got %b/%b want 0/1", i, imem_req, instr_valid); end
    end
    pc_select = 3'd0;
    tick();
    vectors++; if (imem_addr !== 32'h108) begin miscompares++; $display("FAIL hold_release: got %h want %h", imem_addr, 32'h108); end
    tick();
  endtask

  task automatic test_wrap();
    pc_select = 3'd2; immediate = 32'hFFFF_FEF4;
    tick();
    vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_top: got %h want %h", imem_addr, 32'hFFFFFFFC); end
    tick();
    pc_select = 3'd0;
    tick();
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_zero: got %h want %h", imem_addr, 32'h0); end
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    pc_select = 3'd0; imem_ready = 1'b0;
    tick(); tick();
    vectors++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin miscompares++; $display("FAIL pre_rst_fetch: got %h/%b want %h/1", imem_addr, imem_req, 32'h4); end
    rst = 1'b1;
    #1;
    vectors++; if (pc !== 32'h0 || imem_req !== 1'b0) begin miscompares++; $display("FAIL async_rst: got %h/%b want %h/0", pc, imem_req, 32'h0); end
    imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    rst = 1'b0; imem_rdata = 32'h0030_0213;
    vectors++; if (imem_req !== 1'b0 || instruction !== 32'h13) begin miscompares++; $display("FAIL rst_boot: got %b/%h want 0/%h", imem_req, instruction, 32'h13); end
    tick();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_refetch: got %b/%h want 1/%h", imem_req, imem_addr, 32'h0); end
    tick();
    vectors++; if (instruction !== 32'h0030_0213) begin miscompares++; $display("FAIL rst_exec: got %h want %h", instruction, 32'h00300213); end
  endtask

  task automatic test_misalign();
    pc_select = 3'd2; immediate = 32'h2;
    tick();
    vectors++; if (pc !== EXP_MIS_PC) begin miscompares++; $display("FAIL mis_pc: got %h want %h", pc, EXP_MIS_PC); end
    vectors++; if (misaligned !== EXP_MIS_FLG) begin miscompares++; $display("FAIL mis_flag: got %b want %b", misaligned, EXP_MIS_FLG); end
    tick();
    pc_select = 3'd0;
    tick();
    vectors++; if (misaligned !== EXP_MIS_FLG || pc !== EXP_MIS_PC + 32'd4) begin miscompares++; $display("FAIL mis_sticky: got %b/%h want %b/%h", misaligned, pc, EXP_MIS_FLG, EXP_MIS_PC + 32'd4); end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fetch_basic();
    test_delayed_ready();
    test_branch();
    test_jalr();
    test_hold();
    test_wrap();
    test_reset_mid_fetch();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the control unit: holds the program counter, fetches from instruction memory and presents one instruction word at a time for decode.
- Computes the next PC from the decoder's pc_select and immediate, the register-file rs1 value and the ALU branch result.
- Holds the current instruction while the decoder stalls for loads (pc_select = 5).

Parameters:
- WORD, 32, data/address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC on misaligned target (used only with the optional feature).
- NOP_WORD, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven while no valid instruction is held.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- pc_select  in  3  next-PC code from decoder.
- immediate  in  WORD  decoded immediate.
- rs1_data  in  WORD  register-file rs1 read value (JALR base).
- branch_taken  in  1  ALU branch-condition result.
- imem_addr  out  WORD  instruction memory address.
- imem_req  out  1  fetch request.
- imem_rdata  in  WORD  instruction memory read data.
- imem_ready  in  1  read data valid this cycle.
- instruction  out  WORD  instruction to decoder.
- instr_valid  out  1  instruction holds a fetched word.
- pc  out  WORD  address of current instruction.
- pc_plus4  out  WORD  pc + 4 (link value for JAL/JALR).
- misaligned  out  1  sticky misaligned-target flag (0 when the optional feature is out).

Behaviour:
- Reset (async assert, sync release): state = BOOT, pc = RESET_VECTOR, instr_reg = NOP_WORD, instr_valid = 0, imem_req = 0, misaligned = 0.
- Reset mid-fetch abandons the request; any late imem_ready is ignored.
- FSM has three states: BOOT, FETCH, EXEC.
- BOOT: lasts 1 cycle, then goes to FETCH unconditionally.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - Request stays asserted with a stable address until imem_ready = 1.
  - When imem_ready = 1 (same-cycle ready allowed): instr_reg <= imem_rdata, instr_valid <= 1, go to EXEC.
  - Minimum fetch latency is 1 cycle in FETCH.
- EXEC:
  - imem_req = 0; instruction = instr_reg. The decoder's outputs are valid this cycle.
  - pc_select = 5 or 6/7 (hold): stay in EXEC; pc and instr_reg unchanged.
  - Any other pc_select: pc <= next_pc, instr_valid <= 0, go to FETCH.
- instruction output = instr_reg when instr_valid = 1, else NOP_WORD.
- next_pc, all arithmetic modulo 2^WORD, wrap at 32'hFFFF_FFFC + 4 = 0:
  - 0 (sequential / ALU op) -> pc + 4.
  - 1 (branch) -> branch_taken ? pc + immediate : pc + 4.
  - 2 (JAL) -> pc + immediate.
  - 3 (JALR) -> (rs1_data + immediate) with bit0 cleared.
  - 4 (AUIPC) -> pc + 4.
- Without the optional feature, target bits[1:0] are forced to 0.
- pc_plus4 is combinational from pc.
- imem_rdata is ignored outside FETCH.

Optional Feature:
- Macro: INSTRUCTION_FETCH_MISALIGN_TRAP_EN.
- Defined:
  - If next_pc[1:0] != 0 on leaving EXEC, pc <= TRAP_VECTOR and misaligned <= 1.
  - misaligned stays 1 until reset.
- Undefined: low bits are forced to 0 and misaligned is tied to 0.

Test Plan:
- Reset release, imem_ready = 1 constantly: imem_addr = 0 on cycle 2; instruction = imem_rdata in EXEC; next FETCH at pc = 4.
- Before the first imem_ready: instruction = 0x00000013 and instr_valid = 0. imem_ready delayed 3 cycles: imem_req held 3 cycles, imem_addr stable, then EXEC.
- pc = 0x10, pc_select = 1, immediate = 0xFFFFFFF8:
  - branch_taken = 1 -> next fetch address 0x08.
  - branch_taken = 0 -> next fetch address 0x14.
- JALR: rs1_data = 0x101, immediate = 4, pc_select = 3 -> pc = 0x104, and pc_plus4 equals the old pc + 4 during EXEC.
- pc_select = 5 for 2 cycles, then 0: instruction and pc unchanged during the hold, then pc advances by 4. rst pulsed mid-FETCH -> pc = RESET_VECTOR and state = BOOT immediately.
- With the macro defined: JAL, immediate = 2 from pc = 0 -> pc = 0x100 and misaligned = 1. Without the macro: pc = 0x0.
